accum_calc: RTL and testbench
=============================

ACCUM_CALC -- requirements
Module: accum_calc

Interface
REQ-001 Parameter: WIDTH, default 8, operand/accumulator width in bits; legal range 4..16.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 operand  input  WIDTH  B operand for the current command.
REQ-005 op  input  3  command: 000 LOAD, 001 ADD, 010 SUB, 011 AND, 100 OR, 101 XOR, 110 MUL, 111 DIV.
REQ-006 start  input  1  command strobe, sampled at a rising edge.
REQ-007 acc  output  WIDTH  accumulator (A operand and result), registered.
REQ-008 busy  output  1  high while a multi-cycle MUL/DIV runs.
REQ-009 done  output  1  one-cycle pulse on command completion.
REQ-010 zero, carry, ovf, err  output  1 each  registered status flags.

Function
REQ-011 FSM states: IDLE, MUL, DIV; start honoured only in IDLE, ignored while busy=1.
REQ-012 Single-cycle ops (LOAD..XOR): start=1 in IDLE at edge k updates acc and flags at edge k; done=1 for the cycle after edge k; busy stays 0.
REQ-013 LOAD: acc <= operand; carry=0, ovf=0.
REQ-014 ADD: acc <= (acc+operand) mod 2^WIDTH; carry = unsigned carry-out; ovf = signed two's-complement overflow.
REQ-015 SUB: acc <= (acc-operand) mod 2^WIDTH; carry = borrow (acc<operand, unsigned); ovf = signed overflow.
REQ-016 AND/OR/XOR: bitwise; carry=0, ovf=0.
REQ-017 MUL: unsigned shift-add, one multiplier bit per cycle; start at edge k -> state MUL, busy=1 after edge k; result written at edge k+WIDTH; busy=0 and done=1 for the cycle after edge k+WIDTH.
REQ-018 MUL result: acc <= low WIDTH bits of the 2*WIDTH product; carry=1 iff high half nonzero; ovf=0.
REQ-019 DIV: unsigned restoring division acc/operand, one quotient bit per cycle, same timing as MUL (REQ-017); acc <= quotient; remainder discarded; carry=0, ovf=0.
REQ-020 DIV with operand=0: no iteration, busy stays 0; acc unchanged; err=1, carry=0, ovf=0, zero unchanged; done=1 for the cycle after edge k.
REQ-021 zero = (new acc == 0), updated on every completing command except REQ-020.
REQ-022 err cleared by any completing command other than divide-by-zero.
REQ-023 Operand and op captured at the start edge; changes during MUL/DIV have no effect.
REQ-024 acc and flags hold their values between commands; done=0 except completion cycle.
REQ-025 Back-to-back single-cycle commands: start high on consecutive edges executes each command; done high each following cycle.

Reset
REQ-026 rst=1 at an edge: state IDLE; acc=0, busy=0, done=0, zero=1, carry=0, ovf=0, err=0.
REQ-027 rst has priority over start and aborts any MUL/DIV in progress with no done pulse and no partial result.

Verification (WIDTH=8)
REQ-028 LOAD 0x7F, ADD 0x01 -> acc=0x80, ovf=1, carry=0, zero=0; done one cycle after each start.
REQ-029 LOAD 0xFF, ADD 0x01 -> acc=0x00, carry=1, zero=1, ovf=0; then SUB 0x01 -> acc=0xFF, carry=1.
REQ-030 LOAD 0x10, MUL 0x20 -> busy=1 for 8 cycles, then acc=0x00, carry=1, zero=1, done pulse exactly once; start pulses during busy ignored.
REQ-031 LOAD 200 (0xC8), DIV 7 -> acc=0x1C after 8 busy cycles; then DIV 0 -> err=1, acc=0x1C, busy never asserted; then LOAD 0x05 -> err=0.
REQ-032 LOAD 0x03, MUL 0x05, assert rst at busy cycle 4 -> acc=0, busy=0, zero=1, no done pulse; next LOAD 0x0A completes normally.

Source files
------------

// File: rtl/accum_calc.sv
// accum_calc: accumulator calculator with single-cycle ALU ops and
// multi-cycle shift-add multiply / restoring divide.
//
// Ports:
//   clk      system clock, all state changes on the rising edge
//   rst      synchronous active-high reset
//   operand  B operand for the current command
//   op       command: LOAD, ADD, SUB, AND, OR, XOR, MUL, DIV
//   start    command strobe, honoured only while idle
//   acc      accumulator (A operand and result)
//   busy     high while MUL/DIV iterates
//   done     one-cycle completion pulse
//   zero, carry, ovf, err   registered status flags
module accum_calc #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] operand,
    input  logic [2:0]       op,
    input  logic             start,
    output logic [WIDTH-1:0] acc,
    output logic             busy,
    output logic             done,
    output logic             zero,
    output logic             carry,
    output logic             ovf,
    output logic             err
);

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;
    typedef enum logic [2:0] {
        OP_LOAD, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_MUL, OP_DIV
    } op_t;

    localparam logic [4:0] LAST = 5'(WIDTH - 1);

    state_t           state;
    op_t              opc;
    logic [4:0]       cnt;
    // hi/lo form the shared {upper, lower} working pair:
    //   MUL: hi = partial product high half, lo = multiplier shifting out
    //   DIV: hi = partial remainder, lo = dividend shifting out / quotient in
    logic [WIDTH-1:0] hi, lo;
    // MUL: multiplicand; DIV: divisor
    logic [WIDTH-1:0] breg;

    logic [WIDTH:0]   add_full, sub_full;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c, alu_v;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi_n, mul_lo_n;
    logic [WIDTH:0]   div_rs;
    logic [WIDTH-1:0] div_diff, div_hi_n, div_lo_n;
    logic             div_ge;

    assign opc = op_t'(op);

    always_comb begin
        add_full = {1'b0, acc} + {1'b0, operand};
        sub_full = {1'b0, acc} - {1'b0, operand};
        alu_res  = acc;
        alu_c    = 1'b0;
        alu_v    = 1'b0;
        case (opc)
            OP_LOAD: alu_res = operand;
            OP_ADD: begin
                alu_res = add_full[WIDTH-1:0];
                alu_c   = add_full[WIDTH];
                alu_v   = (acc[WIDTH-1] == operand[WIDTH-1]) &&
                          (add_full[WIDTH-1] != acc[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = sub_full[WIDTH-1:0];
                alu_c   = sub_full[WIDTH];
                alu_v   = (acc[WIDTH-1] != operand[WIDTH-1]) &&
                          (sub_full[WIDTH-1] != acc[WIDTH-1]);
            end
            OP_AND:  alu_res = acc & operand;
            OP_OR:   alu_res = acc | operand;
            OP_XOR:  alu_res = acc ^ operand;
            default: alu_res = acc;
        endcase
    end

    // One shift-add step: add multiplicand if the current multiplier bit is
    // set, then shift the {carry, hi, lo} pair right by one.
    always_comb begin
        mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, breg} : '0);
        mul_hi_n = mul_sum[WIDTH:1];
        mul_lo_n = {mul_sum[0], lo[WIDTH-1:1]};
    end

    // One restoring step: shift the next dividend bit into the remainder and
    // subtract the divisor when it fits. The remainder stays below the divisor,
    // so the low WIDTH bits of the difference are exact whenever div_ge is set.
    always_comb begin
        div_rs   = {hi, lo[WIDTH-1]};
        div_ge   = (div_rs >= {1'b0, breg});
        div_diff = div_rs[WIDTH-1:0] - breg;
        div_hi_n = div_ge ? div_diff : div_rs[WIDTH-1:0];
        div_lo_n = {lo[WIDTH-2:0], div_ge};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            zero  <= 1'b1;
            carry <= 1'b0;
            ovf   <= 1'b0;
            err   <= 1'b0;
            cnt   <= '0;
            hi    <= '0;
            lo    <= '0;
            breg  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt <= '0;
                        hi  <= '0;
                        if (opc == OP_MUL) begin
                            state <= MUL;
                            busy  <= 1'b1;
                            breg  <= acc;
                            lo    <= operand;
                        end else if (opc == OP_DIV) begin
                            if (operand == '0) begin
                                err   <= 1'b1;
                                carry <= 1'b0;
                                ovf   <= 1'b0;
                                done  <= 1'b1;
                            end else begin
                                state <= DIV;
                                busy  <= 1'b1;
                                breg  <= operand;
                                lo    <= acc;
                            end
                        end else begin
                            acc   <= alu_res;
                            carry <= alu_c;
                            ovf   <= alu_v;
                            zero  <= (alu_res == '0);
                            err   <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                MUL: begin
                    hi  <= mul_hi_n;
                    lo  <= mul_lo_n;
                    cnt <= cnt + 5'd1;
                    if (cnt == LAST) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        acc   <= mul_lo_n;
                        carry <= |mul_hi_n;
                        ovf   <= 1'b0;
                        err   <= 1'b0;
                        zero  <= (mul_lo_n == '0);
                    end
                end
                DIV: begin
                    hi  <= div_hi_n;
                    lo  <= div_lo_n;
                    cnt <= cnt + 5'd1;
                    if (cnt == LAST) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        acc   <= div_lo_n;
                        carry <= 1'b0;
                        ovf   <= 1'b0;
                        err   <= 1'b0;
                        zero  <= (div_lo_n == '0);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_accum_calc.sv
// tb_accum_calc: directed scoreboard bench for accum_calc (WIDTH=8).
module tb_accum_calc;

    localparam int W = 8;
    localparam longint unsigned M = 64'd1 << W;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] operand;
    logic [2:0]   op;
    logic [W-1:0] acc;
    logic         busy, done, zero, carry, ovf, err;

    accum_calc #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .operand(operand), .op(op), .start(start),
        .acc(acc), .busy(busy), .done(done), .zero(zero), .carry(carry),
        .ovf(ovf), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] acc;
        logic         zero, carry, ovf, err;
        logic         multi;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad = 0;

    longint unsigned m_acc;
    bit m_zero, m_carry, m_ovf, m_err;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic longint sgn(input longint unsigned x);
        return (x >= M / 2) ? longint'(x) - longint'(M) : longint'(x);
    endfunction

    function automatic bit out_of_range(input longint r);
        return (r > longint'(M / 2) - 1) || (r < -longint'(M / 2));
    endfunction

    // Reference model: update model state and push the expected result.
    task automatic model_push(input logic [2:0] o, input longint unsigned b);
        exp_t e;
        longint unsigned p;
        bit multi = 1'b0;
        bit div0 = 1'b0;
        case (o)
            3'd0: begin m_acc = b; m_carry = 0; m_ovf = 0; end
            3'd1: begin
                p = m_acc + b;
                m_ovf = out_of_range(sgn(m_acc) + sgn(b));
                m_carry = (p >= M); m_acc = p % M;
            end
            3'd2: begin
                m_ovf = out_of_range(sgn(m_acc) - sgn(b));
                m_carry = (m_acc < b); m_acc = (m_acc + M - b) % M;
            end
            3'd3: begin m_acc = m_acc & b; m_carry = 0; m_ovf = 0; end
            3'd4: begin m_acc = m_acc | b; m_carry = 0; m_ovf = 0; end
            3'd5: begin m_acc = m_acc ^ b; m_carry = 0; m_ovf = 0; end
            3'd6: begin
                p = m_acc * b; multi = 1'b1;
                m_carry = (p >= M); m_ovf = 0; m_acc = p % M;
            end
            default: begin
                m_carry = 0; m_ovf = 0;
                if (b == 0) div0 = 1'b1;
                else begin m_acc = m_acc / b; multi = 1'b1; end
            end
        endcase
        if (div0) m_err = 1;
        else begin m_err = 0; m_zero = (m_acc == 0); end
        e.acc = m_acc[W-1:0]; e.zero = m_zero; e.carry = m_carry;
        e.ovf = m_ovf; e.err = m_err; e.multi = multi;
        sb.push_back(e);
    endtask

    task automatic pop_compare(input string tag);
        exp_t e;
        check({tag, "_sb_nonempty"}, 64'(sb.size() > 0), 64'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_acc"}, 64'(acc), 64'(e.acc));
            check({tag, "_flags"}, 64'({zero, carry, ovf, err}),
                  64'({e.zero, e.carry, e.ovf, e.err}));
        end
    endtask

    // Issue one command and wait (bounded) for its done pulse.
    task automatic run(input string tag, input logic [2:0] o, input logic [W-1:0] b,
                       input bit pulse);
        int nb = 0;
        bit got = 0;
        bit multi;
        model_push(o, 64'(b));
        multi = sb[$].multi;
        @(negedge clk);
        op = o; operand = b; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0; op = 3'($urandom); operand = W'($urandom);
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (done) got = 1;
            else begin
                if (busy) nb++;
                start = pulse && busy && (nb == 2);
                op = 3'($urandom);
                operand = W'($urandom);
            end
        end
        start = 1'b0;
        check({tag, "_done_seen"}, 64'(got), 64'd1);
        if (got) begin
            pop_compare(tag);
            check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
            check({tag, "_busy_cycles"}, 64'(nb), multi ? 64'(W) : 64'd0);
            @(negedge clk);
            check({tag, "_done_single"}, 64'(done), 64'd0);
        end
    endtask

    initial begin
        int dcount;
        rst = 1'b1; start = 1'b0; op = '0; operand = '0;
        m_acc = 0; m_zero = 1; m_carry = 0; m_ovf = 0; m_err = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_state", 64'({acc, busy, done, zero, carry, ovf, err}),
              64'({8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}));
        rst = 1'b0;

        run("load7f", 3'd0, 8'h7F, 0);
        run("add01_ovf", 3'd1, 8'h01, 0);
        check("add01_ovf_const", 64'({acc, ovf, carry, zero}), 64'({8'h80, 3'b100}));
        run("loadff", 3'd0, 8'hFF, 0);
        run("add01_carry", 3'd1, 8'h01, 0);
        run("sub01_borrow", 3'd2, 8'h01, 0);
        check("sub01_const", 64'({acc, carry}), 64'({8'hFF, 1'b1}));

        run("load10", 3'd0, 8'h10, 0);
        run("mul20", 3'd6, 8'h20, 1);
        check("mul20_const", 64'({acc, carry, zero}), 64'({8'h00, 2'b11}));

        run("loadc8", 3'd0, 8'hC8, 0);
        run("div7", 3'd7, 8'h07, 1);
        check("div7_const", 64'(acc), 64'h1C);
        run("div0", 3'd7, 8'h00, 0);
        check("div0_const", 64'({acc, err}), 64'({8'h1C, 1'b1}));
        run("load05", 3'd0, 8'h05, 0);

        run("loada5", 3'd0, 8'hA5, 0);
        run("and0f", 3'd3, 8'h0F, 0);
        run("or30", 3'd4, 8'h30, 0);
        run("xorff", 3'd5, 8'hFF, 0);
        run("load80", 3'd0, 8'h80, 0);
        run("sub_ovf", 3'd2, 8'h01, 0);
        run("load0c", 3'd0, 8'h0C, 0);
        run("mul0b", 3'd6, 8'h0B, 0);
        run("loadff2", 3'd0, 8'hFF, 0);
        run("div10", 3'd7, 8'h10, 0);
        run("load03b", 3'd0, 8'h03, 0);
        run("div_small", 3'd7, 8'h09, 0);

        // Back-to-back single-cycle commands on consecutive edges.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i > 0) begin
                check("b2b_done", 64'(done), 64'd1);
                pop_compare("b2b");
            end
            case (i)
                0: begin op = 3'd0; operand = 8'h11; start = 1'b1; model_push(3'd0, 64'h11); end
                1: begin op = 3'd1; operand = 8'h22; start = 1'b1; model_push(3'd1, 64'h22); end
                2: begin op = 3'd5; operand = 8'hFF; start = 1'b1; model_push(3'd5, 64'hFF); end
                default: start = 1'b0;
            endcase
        end

        // Reset aborts a multiply in progress.
        run("load03", 3'd0, 8'h03, 0);
        @(negedge clk);
        op = 3'd6; operand = 8'h05; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        dcount = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) dcount++;
        end
        @(negedge clk);
        check("abort_busy_before", 64'(busy), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        m_acc = 0; m_zero = 1; m_carry = 0; m_ovf = 0; m_err = 0;
        @(negedge clk);
        check("abort_state", 64'({acc, busy, done, zero}), 64'({8'h00, 3'b001}));
        repeat (W + 2) begin
            @(negedge clk);
            if (done) dcount++;
        end
        check("abort_no_done", 64'(dcount), 64'd0);
        check("abort_acc_hold", 64'(acc), 64'd0);
        run("load0a", 3'd0, 8'h0A, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
